ttt_game_ctrl: RTL and testbench

Game-state controller for the tic-tac-toe demo. It debounces three push-buttons and moves a cursor over the 3×3 board. It places alternating player marks, detects a win or a draw, and drives the nine 2-bit `position_N` cell codes consumed directly by the TFT rendering top. It sits upstream of the display stage in the `clk50M` domain; the board codes are stable registered values between moves.

---
 rtl/ttt_game_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe game-state controller with debounced push-buttons

// One button path: 2-FF synchronizer, level debouncer and press-edge strobe.
module ttt_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  // Synchronize, accept a level only after it has been stable, strobe on accepted 1->0.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_n_i;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      press_q      <= level_prev_q & ~level_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// Game FSM: cursor, board, turn, win/draw detection.
module ttt_game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk50M,
  input  logic       reset_n,
  input  logic       btn_move_n,
  input  logic       btn_place_n,
  input  logic       btn_new_n,
  output logic [1:0] position_1,
  output logic [1:0] position_2,
  output logic [1:0] position_3,
  output logic [1:0] position_4,
  output logic [1:0] position_5,
  output logic [1:0] position_6,
  output logic [1:0] position_7,
  output logic [1:0] position_8,
  output logic [1:0] position_9,
  output logic [3:0] cursor,
  output logic [1:0] turn,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       illegal
);

  typedef enum logic [1:0] {ST_PLAY, ST_CHECK, ST_WIN, ST_DRAW} state_e;

  logic       press_move;
  logic       press_place;
  logic       press_new;

  state_e     state_q;
  logic [1:0] board_q [9];
  logic [3:0] cursor_q;
  logic [3:0] move_cnt_q;
  logic [1:0] turn_q;
  logic [1:0] winner_q;
  logic       game_over_q;
  logic       illegal_q;

  logic       cur_empty;
  logic       line_done;

  ttt_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_move (
    .clk_i(clk50M), .resetn_i(reset_n), .btn_n_i(btn_move_n), .press_o(press_move)
  );
  ttt_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_place (
    .clk_i(clk50M), .resetn_i(reset_n), .btn_n_i(btn_place_n), .press_o(press_place)
  );
  ttt_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_new (
    .clk_i(clk50M), .resetn_i(reset_n), .btn_n_i(btn_new_n), .press_o(press_new)
  );

  function automatic logic line3(input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] c, input logic [1:0] p);
    return (a == p) && (b == p) && (c == p);
  endfunction

  // Occupancy of the cell under the cursor.
  always_comb begin
    cur_empty = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (cursor_q == 4'(i + 1)) cur_empty = (board_q[i] == 2'b00);
    end
  end

  // Any of the 8 lines fully owned by the player who just moved.
  always_comb begin
    line_done = line3(board_q[0], board_q[1], board_q[2], turn_q) |
                line3(board_q[3], board_q[4], board_q[5], turn_q) |
                line3(board_q[6], board_q[7], board_q[8], turn_q) |
                line3(board_q[0], board_q[3], board_q[6], turn_q) |
                line3(board_q[1], board_q[4], board_q[7], turn_q) |
                line3(board_q[2], board_q[5], board_q[8], turn_q) |
                line3(board_q[0], board_q[4], board_q[8], turn_q) |
                line3(board_q[2], board_q[4], board_q[6], turn_q);
  end

  // Game state machine; new-game outranks every other pulse in every state.
  always_ff @(posedge clk50M) begin
    if (!reset_n) begin
      state_q     <= ST_PLAY;
      for (int i = 0; i < 9; i++) board_q[i] <= 2'b00;
      cursor_q    <= 4'd1;
      move_cnt_q  <= 4'd0;
      turn_q      <= 2'b01;
      winner_q    <= 2'b00;
      game_over_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (press_new) begin
        state_q     <= ST_PLAY;
        for (int i = 0; i < 9; i++) board_q[i] <= 2'b00;
        cursor_q    <= 4'd1;
        move_cnt_q  <= 4'd0;
        turn_q      <= 2'b01;
        winner_q    <= 2'b00;
        game_over_q <= 1'b0;
      end else begin
        case (state_q)
          ST_PLAY: begin
            if (press_place) begin
              if (cur_empty) begin
                for (int i = 0; i < 9; i++) begin
                  if (cursor_q == 4'(i + 1)) board_q[i] <= turn_q;
                end
                move_cnt_q <= move_cnt_q + 4'd1;
                state_q    <= ST_CHECK;
              end else begin
                illegal_q <= 1'b1;
              end
            end else if (press_move) begin
              cursor_q <= (cursor_q == 4'd9) ? 4'd1 : cursor_q + 4'd1;
            end
          end
          ST_CHECK: begin
            if (line_done) begin
              winner_q    <= turn_q;
              game_over_q <= 1'b1;
              state_q     <= ST_WIN;
            end else if (move_cnt_q == 4'd9) begin
              game_over_q <= 1'b1;
              state_q     <= ST_DRAW;
            end else begin
              turn_q  <= (turn_q == 2'b01) ? 2'b10 : 2'b01;
              state_q <= ST_PLAY;
            end
          end
          default: begin
            // WIN and DRAW hold everything until a new game.
          end
        endcase
      end
    end
  end

  assign position_1 = board_q[0];
  assign position_2 = board_q[1];
  assign position_3 = board_q[2];
  assign position_4 = board_q[3];
  assign position_5 = board_q[4];
  assign position_6 = board_q[5];
  assign position_7 = board_q[6];
  assign position_8 = board_q[7];
  assign position_9 = board_q[8];
  assign cursor     = cursor_q;
  assign turn       = turn_q;
  assign winner     = winner_q;
  assign game_over  = game_over_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - scoreboard bench for ttt_game_ctrl
module tb_ttt_game_ctrl;

  logic       clk50M = 1'b0;
  logic       reset_n;
  logic       btn_move_n, btn_place_n, btn_new_n;
  logic [1:0] position_1, position_2, position_3, position_4, position_5;
  logic [1:0] position_6, position_7, position_8, position_9;
  logic [3:0] cursor;
  logic [1:0] turn, winner;
  logic       game_over, illegal;

  always #10 clk50M = ~clk50M;

  ttt_game_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk50M(clk50M), .reset_n(reset_n),
    .btn_move_n(btn_move_n), .btn_place_n(btn_place_n), .btn_new_n(btn_new_n),
    .position_1(position_1), .position_2(position_2), .position_3(position_3),
    .position_4(position_4), .position_5(position_5), .position_6(position_6),
    .position_7(position_7), .position_8(position_8), .position_9(position_9),
    .cursor(cursor), .turn(turn), .winner(winner),
    .game_over(game_over), .illegal(illegal)
  );

  int cyc = 0;
  always @(posedge clk50M) cyc <= cyc + 1;

  logic [27:0] act_vec;
  assign act_vec = {position_1, position_2, position_3, position_4, position_5,
                    position_6, position_7, position_8, position_9,
                    cursor, turn, winner, game_over, illegal};

  typedef struct {
    string       name;
    logic [27:0] val;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [1:0]  m_board [9];
  logic [3:0]  m_cursor, m_moves;
  logic [1:0]  m_turn, m_winner;
  logic        m_over, m_illegal;
  logic [27:0] last_snap;

  function automatic logic [27:0] model_snap();
    return {m_board[0], m_board[1], m_board[2], m_board[3], m_board[4],
            m_board[5], m_board[6], m_board[7], m_board[8],
            m_cursor, m_turn, m_winner, m_over, m_illegal};
  endfunction

  function automatic bit won(input logic [1:0] p);
    return (m_board[0] == p && m_board[1] == p && m_board[2] == p) ||
           (m_board[3] == p && m_board[4] == p && m_board[5] == p) ||
           (m_board[6] == p && m_board[7] == p && m_board[8] == p) ||
           (m_board[0] == p && m_board[3] == p && m_board[6] == p) ||
           (m_board[1] == p && m_board[4] == p && m_board[7] == p) ||
           (m_board[2] == p && m_board[5] == p && m_board[8] == p) ||
           (m_board[0] == p && m_board[4] == p && m_board[8] == p) ||
           (m_board[2] == p && m_board[4] == p && m_board[6] == p);
  endfunction

  task automatic model_new();
    for (int i = 0; i < 9; i++) m_board[i] = 2'b00;
    m_cursor  = 4'd1;
    m_moves   = 4'd0;
    m_turn    = 2'b01;
    m_winner  = 2'b00;
    m_over    = 1'b0;
    m_illegal = 1'b0;
  endtask

  task automatic expect_snap(input string nm, input int at, input bit force_push);
    exp_t        e;
    logic [27:0] s;
    s = model_snap();
    if (force_push || s != last_snap) begin
      e.name = nm;
      e.val  = s;
      e.at   = at;
      exp_q.push_back(e);
      last_snap = s;
    end
  endtask

  // Monitor: every visible output change (or first sample after reset) pops one expectation.
  initial begin
    logic [27:0] prev;
    bit          after_rst;
    exp_t        e;
    prev      = '0;
    after_rst = 1'b1;
    forever begin
      @(posedge clk50M);
      #1;
      if (!reset_n) begin
        after_rst = 1'b1;
      end else begin
        if (after_rst || act_vec !== prev) begin
          after_rst = 1'b0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change act=%h at cycle %0d, required no change", act_vec, cyc);
          end else begin
            e = exp_q.pop_front();
            if (act_vec !== e.val || (e.at >= 0 && e.at != cyc)) begin
              n_fail++;
              $display("FAIL %s act=%h cycle=%0d exp=%h cycle=%0d", e.name, act_vec, cyc, e.val, e.at);
            end
          end
        end
        prev = act_vec;
      end
    end
  end

  task automatic do_reset(input string nm);
    @(negedge clk50M);
    reset_n = 1'b0;
    model_new();
    expect_snap(nm, -1, 1'b1);
    repeat (3) @(negedge clk50M);
    reset_n = 1'b1;
    repeat (2) @(negedge clk50M);
  endtask

  task automatic press(input bit mv, input bit pl, input bit nw, input string nm,
                       input int hold, input bit rst_in_check);
    int c;
    int idx;
    @(negedge clk50M);
    c = cyc;
    btn_move_n  = !mv;
    btn_place_n = !pl;
    btn_new_n   = !nw;
    idx = int'(m_cursor) - 1;
    if (nw) begin
      model_new();
      expect_snap({nm, "_new"}, c + 8, 1'b0);
    end else if (!m_over && pl) begin
      if (m_board[idx] != 2'b00) begin
        m_illegal = 1'b1;
        expect_snap({nm, "_illegal"}, c + 8, 1'b0);
        m_illegal = 1'b0;
        expect_snap({nm, "_illegal_end"}, c + 9, 1'b0);
      end else begin
        m_board[idx] = m_turn;
        m_moves      = m_moves + 4'd1;
        expect_snap({nm, "_place"}, c + 8, 1'b0);
        if (!rst_in_check) begin
          if (won(m_turn)) begin
            m_winner = m_turn;
            m_over   = 1'b1;
          end else if (m_moves == 4'd9) begin
            m_over = 1'b1;
          end else begin
            m_turn = (m_turn == 2'b01) ? 2'b10 : 2'b01;
          end
          expect_snap({nm, "_check"}, c + 9, 1'b0);
        end
      end
    end else if (!m_over && mv) begin
      m_cursor = (m_cursor == 4'd9) ? 4'd1 : m_cursor + 4'd1;
      expect_snap({nm, "_move"}, c + 8, 1'b0);
    end
    repeat (hold) @(negedge clk50M);
    btn_move_n  = 1'b1;
    btn_place_n = 1'b1;
    btn_new_n   = 1'b1;
    if (rst_in_check) begin
      @(negedge clk50M);
      reset_n = 1'b0;
      model_new();
      expect_snap({nm, "_reset_in_check"}, -1, 1'b1);
      repeat (3) @(negedge clk50M);
      reset_n = 1'b1;
    end
    repeat (7) @(negedge clk50M);
  endtask

  task automatic goto_cell(input int target);
    int guard;
    guard = 0;
    while (int'(m_cursor) != target && guard < 9) begin
      press(1'b1, 1'b0, 1'b0, "goto", 7, 1'b0);
      guard++;
    end
  endtask

  task automatic place_at(input int target, input string nm);
    goto_cell(target);
    press(1'b0, 1'b1, 1'b0, nm, 7, 1'b0);
  endtask

  task automatic play_row_win();
    place_at(1, "win_p1");
    place_at(4, "win_p2");
    place_at(2, "win_p3");
    place_at(5, "win_p4");
    place_at(3, "win_p5");
  endtask

  initial begin
    int draw_seq [9];
    reset_n     = 1'b0;
    btn_move_n  = 1'b1;
    btn_place_n = 1'b1;
    btn_new_n   = 1'b1;
    model_new();
    last_snap = model_snap();
    expect_snap("reset_state", -1, 1'b1);
    repeat (3) @(negedge clk50M);
    reset_n = 1'b1;
    repeat (2) @(negedge clk50M);

    // 1: glitch shorter than the debounce window, then a long hold
    @(negedge clk50M);
    btn_move_n = 1'b0;
    repeat (3) @(negedge clk50M);
    btn_move_n = 1'b1;
    repeat (10) @(negedge clk50M);
    press(1'b1, 1'b0, 1'b0, "hold10", 10, 1'b0);

    // 2: cursor wrap
    do_reset("t2_reset");
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 1'b0, "wrap", 7, 1'b0);

    // 3: player 1 row win, then presses in WIN are ignored
    do_reset("t3_reset");
    play_row_win();
    press(1'b0, 1'b1, 1'b0, "win_place_ignored", 7, 1'b0);
    press(1'b1, 1'b0, 1'b0, "win_move_ignored", 7, 1'b0);

    // 4: illegal place on an occupied cell
    press(1'b0, 1'b0, 1'b1, "t4", 7, 1'b0);
    place_at(5, "ill_first");
    press(1'b0, 1'b1, 1'b0, "ill_again", 7, 1'b0);

    // 5: draw
    press(1'b0, 1'b0, 1'b1, "t5", 7, 1'b0);
    draw_seq = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    for (int i = 0; i < 9; i++) place_at(draw_seq[i], "draw");

    // 6: new-game priority in WIN, then reset during CHECK
    press(1'b0, 1'b0, 1'b1, "t6", 7, 1'b0);
    play_row_win();
    press(1'b1, 1'b1, 1'b1, "t6_all", 7, 1'b0);
    press(1'b0, 1'b1, 1'b0, "t6_rst", 7, 1'b1);

    repeat (10) @(negedge clk50M);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations act=%0d required=0 next=%s", exp_q.size(), exp_q[0].name);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
